pipe_result_monitor: RTL and testbench

- Downstream consumer of the 3-bit registered output of the three-level flip-flop pipeline.
- Samples the pipeline result every cycle and detects rising "all-ones" events, i.e. the AND chain has propagated a 1 through all levels.
- Timestamps each event and buffers the timestamps in a small FIFO behind a valid/ready handshake.
- Flags lane mismatch: the three final-level bits must always be equal.

---
 rtl/pipe_mon_pkg.sv | 29 ++
 rtl/ts_fifo.sv | 103 ++++++++++
 rtl/pipe_result_monitor.sv | 126 ++++++++++++
 tb/tb_pipe_result_monitor.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mon_pkg.sv
// ---------------------------------------------------------------------------
// pipe_mon_pkg
//
// Shared definitions for the pipeline result monitor:
//   - default widths/depths for the timestamp, event FIFO and counters
//   - the two legal lane patterns of the three-level pipeline output
//   - a timestamp typedef at the default width
//   - a helper that tells whether a 3-bit sample has all lanes equal
// ---------------------------------------------------------------------------
package pipe_mon_pkg;

    // Default widths and depth used by the monitor and its FIFO.
    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    // The only two lane patterns a healthy pipeline can produce.
    localparam logic [2:0] ALL_ONES  = 3'b111;
    localparam logic [2:0] ALL_ZEROS = 3'b000;

    // Timestamp at the default width.
    typedef logic [TS_W_DEF-1:0] ts_t;

    // True when all three final-level bits agree.
    function automatic logic lanes_agree(input logic [2:0] sample);
        return (sample == ALL_ONES) || (sample == ALL_ZEROS);
    endfunction

endpackage : pipe_mon_pkg

// File: rtl/ts_fifo.sv
// ---------------------------------------------------------------------------
// ts_fifo
//
// Small synchronous FIFO, DEPTH entries of W bits, with a registered head.
// The head register keeps showing the last value it held once the FIFO
// drains, so a consumer never sees stale storage from an unused slot.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (empties the FIFO, head=0)
//   push       write push_data (accepted when not full, or when full and
//              a pop happens in the same cycle)
//   push_data  data to write
//   pop        remove the head entry (ignored when empty)
//   full       occupancy == DEPTH
//   empty      occupancy == 0
//   head       registered oldest entry
// ---------------------------------------------------------------------------
module ts_fifo
    import pipe_mon_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    assign pop_ok     = pop && !empty;
    assign push_ok    = push && (!full || pop_ok);
    assign rd_ptr_nxt = rd_ptr + AW'(1);

    // Storage array; no reset needed because the head register and the
    // occupancy count decide what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy. Pointers wrap naturally because DEPTH is a
    // power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head register. On a pop the next-oldest entry moves up if one exists;
    // otherwise a simultaneous push becomes the new head. When the FIFO was
    // empty, the pushed value goes straight to the head. If nothing
    // replaces it, the head keeps its previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
        end else if (pop_ok) begin
            if (count > CW'(1)) begin
                head <= mem[rd_ptr_nxt];
            end else if (push_ok) begin
                head <= push_data;
            end
        end else if (push_ok && empty) begin
            head <= push_data;
        end
    end

endmodule : ts_fifo

// File: rtl/pipe_result_monitor.sv
// ---------------------------------------------------------------------------
// pipe_result_monitor
//
// Watches the 3-bit registered output of the three-level flip-flop pipeline.
// A rising "all ones" sample is an event. Each event is timestamped with a
// free-running counter and queued in a small FIFO that the consumer drains
// through a valid/ready handshake. Lane disagreement raises a sticky error.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_data     pipeline result {q3_2,q3_1,q3_0}
//   clr         synchronous clear of counters and sticky flags
//   m_valid     FIFO head holds a timestamp
//   m_ready     consumer accepts the head
//   m_data      timestamp at the FIFO head (holds its value when empty)
//   evt_count   saturating count of detected events
//   drop_count  saturating count of events lost to a full FIFO
//   overflow    sticky, set on any drop
//   lane_err    sticky, set when the registered sample is not 000/111
// ---------------------------------------------------------------------------
module pipe_result_monitor
    import pipe_mon_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       in_data,
    input  logic             clr,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [TS_W-1:0]  m_data,
    output logic [CNT_W-1:0] evt_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow,
    output logic             lane_err
);

    logic [2:0]      r_in;
    logic [2:0]      r_prev;
    logic [TS_W-1:0] ts;
    logic            evt;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            drop;

    // Input sample, previous sample and the free-running timestamp. The
    // timestamp wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in   <= ALL_ZEROS;
            r_prev <= ALL_ZEROS;
            ts     <= '0;
        end else begin
            r_in   <= in_data;
            r_prev <= r_in;
            ts     <= ts + TS_W'(1);
        end
    end

    // Rising all-ones detection: a held 111 only counts once.
    assign evt = (r_in == ALL_ONES) && (r_prev != ALL_ONES);

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;

    // An event is lost only when the FIFO is full and no slot frees up in
    // the same cycle.
    assign drop = evt && fifo_full && !pop;

    ts_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (evt),
        .push_data (ts),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (m_data)
    );

    // Saturating event and drop counters. A clear wins over a concurrent
    // event, though the event itself still goes to the FIFO or is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_count  <= '0;
            drop_count <= '0;
        end else if (clr) begin
            evt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (evt && (evt_count != '1)) begin
                evt_count <= evt_count + CNT_W'(1);
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    // Sticky flags, cleared only by clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            lane_err <= 1'b0;
        end else if (clr) begin
            overflow <= 1'b0;
            lane_err <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (!lanes_agree(r_in)) begin
                lane_err <= 1'b1;
            end
        end
    end

endmodule : pipe_result_monitor

// File: tb/tb_pipe_result_monitor.sv
// ---------------------------------------------------------------------------
// tb_pipe_result_monitor
//
// Drives two monitors (16-bit and 4-bit timestamps) with the same stimulus
// and compares both against a queue-based reference model of the event,
// timestamp, FIFO and flag rules.
// ---------------------------------------------------------------------------
module tb_pipe_result_monitor;

    localparam int DEPTH   = 4;
    localparam int CNT_MAX = 255;

    logic        clk;
    logic        rst_n;
    logic [2:0]  in_data;
    logic        clr;
    logic        m_ready;

    logic        m_valid;
    logic [15:0] m_data;
    logic [7:0]  evt_count;
    logic [7:0]  drop_count;
    logic        overflow;
    logic        lane_err;

    logic        m_valid4;
    logic [3:0]  m_data4;
    logic [7:0]  evt_count4;
    logic [7:0]  drop_count4;
    logic        overflow4;
    logic        lane_err4;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [2:0] mdl_rin;
    logic [2:0] mdl_rprev;
    int         mdl_ts;
    int         mdl_q[$];
    int         mdl_head;
    int         mdl_evt;
    int         mdl_drop;
    bit         mdl_ovf;
    bit         mdl_lane;

    pipe_result_monitor #(.TS_W(16), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .clr        (clr),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .evt_count  (evt_count),
        .drop_count (drop_count),
        .overflow   (overflow),
        .lane_err   (lane_err)
    );

    pipe_result_monitor #(.TS_W(4), .DEPTH(DEPTH), .CNT_W(8)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .clr        (clr),
        .m_valid    (m_valid4),
        .m_ready    (m_ready),
        .m_data     (m_data4),
        .evt_count  (evt_count4),
        .drop_count (drop_count4),
        .overflow   (overflow4),
        .lane_err   (lane_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        mdl_rin   = 3'b000;
        mdl_rprev = 3'b000;
        mdl_ts    = 0;
        mdl_q.delete();
        mdl_head  = 0;
        mdl_evt   = 0;
        mdl_drop  = 0;
        mdl_ovf   = 1'b0;
        mdl_lane  = 1'b0;
    endfunction

    // One clock edge of the monitor's rules, using pre-edge state.
    function automatic void modelStep(input logic [2:0] d, input logic rdy,
                                      input logic c);
        bit event_now;
        bit dropped;
        bit bad_lane;
        event_now = (mdl_rin == 3'b111) && (mdl_rprev != 3'b111);
        bad_lane  = !((mdl_rin == 3'b000) || (mdl_rin == 3'b111));
        dropped   = 1'b0;
        if (rdy && (mdl_q.size() > 0)) begin
            void'(mdl_q.pop_front());
        end
        if (event_now) begin
            if (mdl_q.size() < DEPTH) mdl_q.push_back(mdl_ts);
            else dropped = 1'b1;
        end
        if (mdl_q.size() > 0) mdl_head = mdl_q[0];
        if (c) begin
            mdl_evt  = 0;
            mdl_drop = 0;
            mdl_ovf  = 1'b0;
            mdl_lane = 1'b0;
        end else begin
            if (event_now && mdl_evt < CNT_MAX) mdl_evt++;
            if (dropped && mdl_drop < CNT_MAX) mdl_drop++;
            if (dropped) mdl_ovf = 1'b1;
            if (bad_lane) mdl_lane = 1'b1;
        end
        mdl_rprev = mdl_rin;
        mdl_rin   = d;
        mdl_ts    = (mdl_ts + 1) % 65536;
    endfunction

    task automatic checkAll();
        checkOutput("m_valid",     32'(m_valid),     32'(mdl_q.size() > 0));
        checkOutput("m_data",      32'(m_data),      32'(mdl_head));
        checkOutput("evt_count",   32'(evt_count),   32'(mdl_evt));
        checkOutput("drop_count",  32'(drop_count),  32'(mdl_drop));
        checkOutput("overflow",    32'(overflow),    32'(mdl_ovf));
        checkOutput("lane_err",    32'(lane_err),    32'(mdl_lane));
        checkOutput("m_valid_ts4", 32'(m_valid4),    32'(mdl_q.size() > 0));
        checkOutput("m_data_ts4",  32'(m_data4),     32'(mdl_head % 16));
        checkOutput("lane_err_ts4", 32'(lane_err4),  32'(mdl_lane));
        checkOutput("overflow_ts4", 32'(overflow4),  32'(mdl_ovf));
    endtask

    // Called at a falling edge: drive inputs, advance the model, check
    // just after the rising edge, then return at the next falling edge.
    task automatic applyStimulus(input logic [2:0] d, input logic rdy,
                                 input logic c);
        in_data = d;
        m_ready = rdy;
        clr     = c;
        modelStep(d, rdy, c);
        @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        in_data = 3'b000;
        clr     = 1'b0;
        m_ready = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkAll();

        // Held 111 after reset release: exactly one event, timestamp 1.
        in_data = 3'b111;
        rst_n   = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(3'b111, 1'b1, 1'b0);
        checkOutput("first_evt_ts", 32'(m_data), 32'd1);
        checkOutput("first_evt_cnt", 32'(evt_count), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(3'b000, 1'b0, 1'b0);

        // Six pulses with no consumer: FIFO fills, two drops.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'b111, 1'b0, 1'b0);
            applyStimulus(3'b000, 1'b0, 1'b0);
        end
        checkOutput("fill_drop_count", 32'(drop_count), 32'd2);

        // Full FIFO with a pop in the same cycle as a new event.
        applyStimulus(3'b111, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b1, 1'b0);
        applyStimulus(3'b000, 1'b0, 1'b0);
        checkOutput("full_pop_drop", 32'(drop_count), 32'd2);

        // Drain everything in order.
        for (int i = 0; i < 6; i++) applyStimulus(3'b000, 1'b1, 1'b0);

        // Lane error, stays through normal traffic, then clear.
        applyStimulus(3'b101, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b111, 1'b1, 1'b0);
            applyStimulus(3'b000, 1'b1, 1'b0);
        end
        applyStimulus(3'b000, 1'b1, 1'b1);
        applyStimulus(3'b000, 1'b1, 1'b0);

        // Events spaced 20 cycles apart exercise the 4-bit timestamp wrap.
        for (int e = 0; e < 4; e++) begin
            applyStimulus(3'b111, 1'b1, 1'b0);
            for (int i = 0; i < 19; i++) applyStimulus(3'b000, 1'b1, 1'b0);
        end

        // Drive the event counter into saturation, then clear it.
        for (int i = 0; i < 270; i++) begin
            applyStimulus(3'b111, 1'b1, 1'b0);
            applyStimulus(3'b000, 1'b1, 1'b0);
        end
        checkOutput("evt_saturated", 32'(evt_count), 32'(CNT_MAX));
        applyStimulus(3'b000, 1'b1, 1'b1);

        // Random traffic, mostly legal samples, occasional clear.
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] d;
            logic       r;
            logic       c;
            if ($urandom_range(0, 15) == 0) d = 3'($urandom_range(0, 7));
            else d = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
            r = ($urandom_range(0, 3) != 0) ? ((i / 200) % 2 == 0) : 1'b0;
            c = ($urandom_range(0, 60) == 0);
            applyStimulus(d, r, c);
        end
        applyStimulus(3'b000, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(3'b000, 1'b1, 1'b0);

        // Queue four events, drain one, then reset asynchronously mid-cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b111, 1'b0, 1'b0);
            applyStimulus(3'b000, 1'b0, 1'b0);
        end
        applyStimulus(3'b000, 1'b1, 1'b0);
        checkOutput("pre_reset_valid", 32'(m_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        @(negedge clk);
        in_data = 3'b111;
        rst_n   = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(3'b111, 1'b0, 1'b0);
        checkOutput("post_reset_ts", 32'(m_data), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(3'b000, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_result_monitor
